// File: rtl/dmem_block_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_block_responder_if
// Bundles the core's data-memory signals: the 32-bit word port and the
// 256-bit block port with its request/valid handshake.
//   master : core / cache side (drives requests, receives data and valids)
//   slave  : memory side (dmem_block_responder)
// Word port : data_address_2DM, MemRead_2DM, MemWrite_2DM, data_write_2DM,
//             data_write_size_2DM -> data_read_fDM
// Block port: dBlkRead, dBlkWrite, block_write_2DM -> block_read_fDM,
//             block_read_fDM_valid, block_write_fDM_valid
// -----------------------------------------------------------------------------
interface dmem_block_responder_if;
    logic [31:0]  data_address_2DM;
    logic         MemRead_2DM;
    logic         MemWrite_2DM;
    logic [31:0]  data_write_2DM;
    logic [1:0]   data_write_size_2DM;
    logic [31:0]  data_read_fDM;
    logic         dBlkRead;
    logic         dBlkWrite;
    logic [255:0] block_write_2DM;
    logic [255:0] block_read_fDM;
    logic         block_read_fDM_valid;
    logic         block_write_fDM_valid;

    modport master (
        output data_address_2DM, MemRead_2DM, MemWrite_2DM, data_write_2DM,
               data_write_size_2DM, dBlkRead, dBlkWrite, block_write_2DM,
        input  data_read_fDM, block_read_fDM, block_read_fDM_valid,
               block_write_fDM_valid
    );

    modport slave (
        input  data_address_2DM, MemRead_2DM, MemWrite_2DM, data_write_2DM,
               data_write_size_2DM, dBlkRead, dBlkWrite, block_write_2DM,
        output data_read_fDM, block_read_fDM, block_read_fDM_valid,
               block_write_fDM_valid
    );
endinterface

// File: rtl/dmem_block_responder.sv
// -----------------------------------------------------------------------------
// dmem_block_responder
// Data-memory model behind the core's data interface. Storage is
// 2^LINE_ADDR_BITS lines of 256 bits, not cleared by reset.
//   - Word port: combinational read of the aligned word, byte-lane write on
//     the rising edge (size 1..3, 0 = 4 bytes, bytes past offset 3 dropped).
//   - Block port: level request, completion after RD/WR_LATENCY edges with a
//     one-cycle valid pulse, then held off until the request drops.
// Ports:
//   CLK   : clock, rising edge
//   RESET : asynchronous active-low reset
//   bus   : dmem_block_responder_if.slave (word + block port)
// -----------------------------------------------------------------------------
module dmem_block_responder #(
    parameter int LINE_ADDR_BITS = 6,
    parameter int RD_LATENCY     = 4,
    parameter int WR_LATENCY     = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    dmem_block_responder_if.slave  bus
);

    localparam int NLINES = 1 << LINE_ADDR_BITS;

    typedef enum logic [2:0] {
        IDLE, RD_BUSY, WR_BUSY, RESP, WAIT_DROP
    } state_t;

    // ---------------------------------------------------------------- storage
    logic [255:0] mem_q [NLINES];

    // Word-port address decode (upper address bits wrap).
    logic [LINE_ADDR_BITS-1:0] w_line;
    logic [2:0]                w_word;
    logic [1:0]                w_byte;
    logic [7:0]                w_bit;   // bit offset of the word within a line

    assign w_line = bus.data_address_2DM[LINE_ADDR_BITS+4:5];
    assign w_word = bus.data_address_2DM[4:2];
    assign w_byte = bus.data_address_2DM[1:0];
    assign w_bit  = {w_word, 5'd0};

    assign bus.data_read_fDM = mem_q[w_line][w_bit +: 32];

    // Byte-lane merge for word writes. Data is shifted up to the start byte;
    // anything shifted past bit 31 (and mask bits past lane 3) is discarded,
    // so a write never spills into the next word.
    logic [2:0]   wsize;
    logic [7:0]   mask_wide;
    logic [3:0]   byte_en;
    logic [31:0]  wdata_sh;
    logic [31:0]  word_old;
    logic [31:0]  word_new;
    logic [255:0] line_new;

    always_comb begin
        wsize     = (bus.data_write_size_2DM == 2'd0) ? 3'd4 : {1'b0, bus.data_write_size_2DM};
        mask_wide = ((8'd1 << wsize) - 8'd1) << w_byte;
        byte_en   = mask_wide[3:0];
        wdata_sh  = bus.data_write_2DM << {w_byte, 3'd0};
        word_old  = mem_q[w_line][w_bit +: 32];
        word_new  = word_old;
        for (int j = 0; j < 4; j++) begin
            if (byte_en[j]) word_new[8*j +: 8] = wdata_sh[8*j +: 8];
        end
        line_new = mem_q[w_line];
        line_new[w_bit +: 32] = word_new;
    end

    // ------------------------------------------------------------ block FSM
    state_t                    state_q, state_d;
    logic [7:0]                cnt_q, cnt_d;
    logic [LINE_ADDR_BITS-1:0] line_q, line_d;
    logic [255:0]              wdata_q, wdata_d;
    logic [255:0]              rdata_q, rdata_d;
    logic                      op_wr_q, op_wr_d;   // 1 = current transfer is a write
    logic                      blk_commit;         // block write lands this edge

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            op_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            op_wr_q <= op_wr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        line_d     = line_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        op_wr_d    = op_wr_q;
        blk_commit = 1'b0;
        case (state_q)
            IDLE: begin
                // Write wins when both requests are up.
                if (bus.dBlkWrite) begin
                    line_d  = w_line;
                    wdata_d = bus.block_write_2DM;
                    cnt_d   = 8'(WR_LATENCY - 1);
                    op_wr_d = 1'b1;
                    state_d = WR_BUSY;
                end else if (bus.dBlkRead) begin
                    line_d  = w_line;
                    cnt_d   = 8'(RD_LATENCY - 1);
                    op_wr_d = 1'b0;
                    state_d = RD_BUSY;
                end
            end
            RD_BUSY: begin
                // A dropped request aborts before it can complete.
                if (!bus.dBlkRead) begin
                    state_d = IDLE;
                end else if (cnt_q == 8'd0) begin
                    rdata_d = mem_q[line_q];
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            WR_BUSY: begin
                if (!bus.dBlkWrite) begin
                    state_d = IDLE;
                end else if (cnt_q == 8'd0) begin
                    blk_commit = 1'b1;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP:      state_d = WAIT_DROP;
            WAIT_DROP: if (!bus.dBlkRead && !bus.dBlkWrite) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Storage update. The block write is issued last so it overrides a word
    // write to the same line on the same edge.
    always_ff @(posedge CLK) begin
        if (bus.MemWrite_2DM) mem_q[w_line] <= line_new;
        if (blk_commit)       mem_q[line_q] <= wdata_q;
    end

    // Valids decode straight from state so reset clears them immediately.
    assign bus.block_read_fDM        = rdata_q;
    assign bus.block_read_fDM_valid  = (state_q == RESP) && !op_wr_q;
    assign bus.block_write_fDM_valid = (state_q == RESP) &&  op_wr_q;

    // Word reads are combinational, so the read strobe carries no information.
    logic unused_sigs;
    assign unused_sigs = ^{bus.MemRead_2DM, bus.data_address_2DM[31:LINE_ADDR_BITS+5],
                           mask_wide[7:4]};

endmodule

// File: tb/tb_dmem_block_responder.sv
module tb_dmem_block_responder;
    localparam int LAT = 4;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    dmem_block_responder_if bus();

    dmem_block_responder #(
        .LINE_ADDR_BITS(6), .RD_LATENCY(LAT), .WR_LATENCY(LAT)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Scoreboard of expected block completions: kind, cycle and read data.
    typedef struct {
        logic         is_wr;
        int           at;
        logic [255:0] data;
    } rsp_t;
    rsp_t sb[$];

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] data;
        logic [31:0] raddr;
        logic [31:0] exp;
    } wvec_t;
    wvec_t vt[9];

    rsp_t         e;
    logic [255:0] blk_a, blk_b, ones;

    always @(negedge CLK) begin
        if (bus.block_read_fDM_valid || bus.block_write_fDM_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL spurious_valid rd=%0b wr=%0b cyc=%0d",
                         bus.block_read_fDM_valid, bus.block_write_fDM_valid, cyc);
            end else begin
                e = sb.pop_front();
                if (bus.block_write_fDM_valid !== e.is_wr ||
                    bus.block_read_fDM_valid !== !e.is_wr || cyc != e.at ||
                    (!e.is_wr && bus.block_read_fDM !== e.data)) begin
                    errors++;
                    $display("FAIL blk_rsp got rd=%0b wr=%0b cyc=%0d data=%h exp wr=%0b cyc=%0d data=%h",
                             bus.block_read_fDM_valid, bus.block_write_fDM_valid, cyc,
                             bus.block_read_fDM, e.is_wr, e.at, e.data);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    task automatic chk_drained(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s pending=%0d exp 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic word_wr(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        bus.data_address_2DM = a;
        bus.data_write_size_2DM = s;
        bus.data_write_2DM = d;
        bus.MemWrite_2DM = 1'b1;
        tick(1);
        bus.MemWrite_2DM = 1'b0;
    endtask

    task automatic rd_word(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus.data_address_2DM = a;
        #1;
        chk(name, {224'd0, bus.data_read_fDM}, {224'd0, exp});
    endtask

    // Raise a block request now; it is accepted on the next edge.
    task automatic blk_req(input logic wr, input logic [31:0] a,
                           input logic [255:0] d, input logic [255:0] exp);
        bus.data_address_2DM = a;
        bus.block_write_2DM = d;
        if (wr) bus.dBlkWrite = 1'b1;
        else    bus.dBlkRead  = 1'b1;
        sb.push_back('{wr, cyc + 1 + LAT, exp});
    endtask

    initial begin
        bus.data_address_2DM = '0;
        bus.MemRead_2DM = 1'b0;
        bus.MemWrite_2DM = 1'b0;
        bus.data_write_2DM = '0;
        bus.data_write_size_2DM = '0;
        bus.dBlkRead = 1'b0;
        bus.dBlkWrite = 1'b0;
        bus.block_write_2DM = '0;
        for (int w = 0; w < 8; w++) begin
            blk_a[32*w +: 32] = 32'(w + 1);
            blk_b[32*w +: 32] = 32'hB000_0000 + 32'(w);
        end
        ones = '1;

        vt[0] = '{32'h040, 2'd0, 32'hDEADBEEF, 32'h040, 32'hDEADBEEF};
        vt[1] = '{32'h041, 2'd1, 32'h000000AA, 32'h040, 32'hDEADAAEF};
        vt[2] = '{32'h042, 2'd3, 32'h00123456, 32'h043, 32'h3456AAEF};
        vt[3] = '{32'h044, 2'd0, 32'h11223344, 32'h044, 32'h11223344};
        vt[4] = '{32'h047, 2'd2, 32'h0000BBCC, 32'h044, 32'hCC223344};
        vt[5] = '{32'h045, 2'd2, 32'h00005566, 32'h046, 32'hCC556644};
        vt[6] = '{32'h808, 2'd0, 32'hCAFEF00D, 32'h008, 32'hCAFEF00D};
        vt[7] = '{32'h00C, 2'd1, 32'h00000077, 32'h008, 32'hCAFEF00D};
        vt[8] = '{32'h060, 2'd0, 32'h0BADF00D, 32'h860, 32'h0BADF00D};

        // Reset state
        #2;
        chk("rst_rdata", bus.block_read_fDM, '0);
        chk("rst_valids", {254'd0, bus.block_read_fDM_valid, bus.block_write_fDM_valid}, '0);
        tick(2);
        RESET = 1'b1;
        tick(1);

        // Word-port vectors
        for (int i = 0; i < 9; i++) begin
            word_wr(vt[i].addr, vt[i].size, vt[i].data);
            rd_word($sformatf("word_vec%0d", i), vt[i].raddr, vt[i].exp);
        end

        // Read and write on the same edge: read shows the old word
        word_wr(32'h04C, 2'd0, 32'h12345678);
        bus.data_address_2DM = 32'h04C;
        bus.data_write_2DM = 32'hFFFFFFFF;
        bus.MemRead_2DM = 1'b1;
        bus.MemWrite_2DM = 1'b1;
        #1;
        chk("rdwr_pre", {224'd0, bus.data_read_fDM}, {224'd0, 32'h12345678});
        tick(1);
        bus.MemWrite_2DM = 1'b0;
        bus.MemRead_2DM = 1'b0;
        rd_word("rdwr_post", 32'h04C, 32'hFFFFFFFF);

        // Block write of line 1, held well past completion
        blk_req(1'b1, 32'h020, blk_a, '0);
        tick(LAT + 10);
        chk_drained("blkwr_done");
        bus.dBlkWrite = 1'b0;
        tick(2);
        rd_word("blkwr_w0", 32'h020, 32'd1);
        rd_word("blkwr_w7", 32'h03C, 32'd8);

        // Block read of line 1, held, then re-requested
        blk_req(1'b0, 32'h020, '0, blk_a);
        tick(LAT + 10);
        chk_drained("blkrd1_done");
        bus.dBlkRead = 1'b0;
        tick(2);
        blk_req(1'b0, 32'h020, '0, blk_a);
        tick(LAT + 2);
        chk_drained("blkrd2_done");
        bus.dBlkRead = 1'b0;
        tick(2);
        chk("blkrd_hold", bus.block_read_fDM, blk_a);

        // Read and write together: write only; word write during BUSY overwritten
        bus.dBlkRead = 1'b1;
        blk_req(1'b1, 32'h040, blk_b, '0);
        tick(2);
        word_wr(32'h044, 2'd0, 32'h99999999);
        rd_word("busy_word", 32'h044, 32'h99999999);
        tick(LAT + 3);
        chk_drained("both_done");
        rd_word("blk_overwrites", 32'h044, 32'hB0000001);
        bus.dBlkRead = 1'b0;
        bus.dBlkWrite = 1'b0;
        tick(3);
        chk_drained("both_no_read");

        // Abort a block write to line 3
        bus.data_address_2DM = 32'h060;
        bus.block_write_2DM = ones;
        bus.dBlkWrite = 1'b1;
        tick(2);
        bus.dBlkWrite = 1'b0;
        tick(LAT + 4);
        chk_drained("abort_no_valid");
        rd_word("abort_mem", 32'h060, 32'h0BADF00D);

        // Asynchronous reset during RD_BUSY
        bus.data_address_2DM = 32'h040;
        bus.dBlkRead = 1'b1;
        tick(2);
        #2;
        RESET = 1'b0;
        #1;
        chk("rst_mid_rdata", bus.block_read_fDM, '0);
        chk("rst_mid_valids", {254'd0, bus.block_read_fDM_valid, bus.block_write_fDM_valid}, '0);
        bus.dBlkRead = 1'b0;
        tick(1);
        RESET = 1'b1;
        tick(1);
        rd_word("rst_keeps_mem", 32'h03C, 32'd8);
        blk_req(1'b0, 32'h020, '0, blk_a);
        tick(LAT + 2);
        chk_drained("after_rst_done");
        bus.dBlkRead = 1'b0;
        tick(3);

        chk_drained("final");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
